iter_right_shifter: RTL

- Multi-cycle logical right shifter for 8-bit operands. Accepts a full 3-bit shift amount (0..7) via a valid/ready handshake.
- Realises the shift as repeated 0..3-position steps, one step per clock, through a small combinational step stage.
- Sits upstream of downstream consumers as the sequenced front end of the 2-bit shift datapath. Result is held under output backpressure.

---
 rtl/iter_shift_pkg.sv | 13 +
 rtl/iter_right_shifter_shift_step.sv | 10 +
 rtl/iter_right_shifter.sv | 77 +++++++
 3 files changed

// File: rtl/iter_shift_pkg.sv
// Shared widths and FSM state type for the iterative right shifter.
package iter_shift_pkg;
   localparam int WIDTH    = 8;
   localparam int SHIFT_W  = 3;
   localparam int STEP_W   = 2;
   localparam int MAX_STEP = (1 << STEP_W) - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/iter_right_shifter_shift_step.sv
// One combinational step of 0..MAX_STEP positions, logical right shift with zero fill.
module shift_step
   import iter_shift_pkg::*;
(
   input  logic [WIDTH-1:0]  work,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  result
);
   assign result = work >> step;
endmodule

// File: rtl/iter_right_shifter.sv
// Logical right shift of an 8-bit operand in ceil(shift/3) single-cycle steps; result valid 1+ceil(shift/3) cycles after accept.
// Result and step count are held in DONE until out_ready; no new request is accepted until then.
module iter_right_shifter
   import iter_shift_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data,
   input  logic [SHIFT_W-1:0] shift,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   shout,
   output logic [SHIFT_W-1:0] steps
);
   state_t               state, state_nxt;
   logic [WIDTH-1:0]     work;
   logic [SHIFT_W-1:0]   rem;
   logic [STEP_W-1:0]    step;
   logic [SHIFT_W-1:0]   rem_left;
   logic [WIDTH-1:0]     stepped;

   // Saturate the step to what is left so rem can never underflow.
   assign step     = (rem > SHIFT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : rem[STEP_W-1:0];
   assign rem_left = rem - {{(SHIFT_W-STEP_W){1'b0}}, step};

   shift_step u_step (
      .work   (work),
      .step   (step),
      .result (stepped)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = (shift == '0) ? DONE : SHIFT;
         SHIFT:   if (rem_left == '0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work  <= '0;
         rem   <= '0;
         steps <= '0;
         shout <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               work  <= data;
               rem   <= shift;
               steps <= '0;
               if (shift == '0) shout <= data;
            end
            SHIFT: begin
               work  <= stepped;
               rem   <= rem_left;
               steps <= steps + SHIFT_W'(1);
               // shout only moves on entry to DONE, so it holds otherwise.
               if (rem_left == '0) shout <= stepped;
            end
            default: ;
         endcase
      end
   end
endmodule
